// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-unit bundle: register ids and stage flags in, forward/stall/flush
// controls and the stall statistics counter out.
interface hazard_controller_if;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic        BranchD, PCSrcD, MultiCycleE;
    logic [3:0]  MultiLenE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD;
    logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM, ExBusy;
    logic [15:0] StallCount;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MultiCycleE, MultiLenE,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, StallE, FlushD, FlushE, BubbleM, ExBusy, StallCount
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MultiCycleE, MultiLenE,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, StallE, FlushD, FlushE, BubbleM, ExBusy, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use/branch stalls, a multi-cycle
// Execute hold FSM and a saturating stalled-cycle counter.
module hazard_controller (
    input  logic          clk,
    input  logic          reset,
    hazard_controller_if.slave hz
);
    typedef enum logic [0:0] {StIdle, StBusy} stateT;

    stateT       stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic [15:0] stallCountQ;
    logic        mcStall, lwStall, brStall, stallAny;
    logic [1:0]  fwdAE, fwdBE;
    logic        fwdAD, fwdBD;

    // Memory-stage result wins over Writeback since it is the younger write.
    function automatic logic [1:0] fwdExec(input logic [4:0] src, input logic [4:0] wrM,
                                           input logic regWrM, input logic [4:0] wrW,
                                           input logic regWrW);
        if (src != 5'd0 && regWrM && src == wrM) begin
            return 2'b10;
        end else if (src != 5'd0 && regWrW && src == wrW) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        fwdAE = fwdExec(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
        fwdBE = fwdExec(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
        fwdAD = (hz.RsD != 5'd0) && hz.RegWriteM && (hz.RsD == hz.WriteRegM);
        fwdBD = (hz.RtD != 5'd0) && hz.RegWriteM && (hz.RtD == hz.WriteRegM);
    end

    always_comb begin
        lwStall = hz.MemtoRegE && (hz.RtE != 5'd0) && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
        brStall = hz.BranchD &&
                  ((hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                    ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                   (hz.MemtoRegM && (hz.WriteRegM != 5'd0) &&
                    ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
    end

    // Stall on the issue cycle plus every BUSY cycle except the last, giving N held cycles.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        mcStall = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (hz.MultiCycleE && hz.MultiLenE != 4'd0) begin
                    mcStall = 1'b1;
                    cntD    = hz.MultiLenE;
                    stateD  = StBusy;
                end
            end
            StBusy: begin
                cntD = cntQ - 4'd1;
                if (cntQ == 4'd1) begin
                    stateD = StIdle;
                end else begin
                    mcStall = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign stallAny = lwStall | brStall | mcStall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ      <= StIdle;
            cntQ        <= 4'd0;
            stallCountQ <= 16'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (stallAny && stallCountQ != 16'hFFFF) begin
                stallCountQ <= stallCountQ + 16'd1;
            end
        end
    end

    assign hz.ForwardAE  = reset ? 2'b00 : fwdAE;
    assign hz.ForwardBE  = reset ? 2'b00 : fwdBE;
    assign hz.ForwardAD  = ~reset & fwdAD;
    assign hz.ForwardBD  = ~reset & fwdBD;
    assign hz.StallF     = ~reset & stallAny;
    assign hz.StallD     = ~reset & stallAny;
    assign hz.StallE     = ~reset & mcStall;
    assign hz.BubbleM    = ~reset & mcStall;
    // Execute is held during a multi-cycle op, so it must not also be flushed.
    assign hz.FlushE     = ~reset & (lwStall | brStall) & ~mcStall;
    assign hz.FlushD     = ~reset & hz.PCSrcD & ~stallAny;
    assign hz.ExBusy     = ~reset & (stateQ == StBusy);
    assign hz.StallCount = stallCountQ;
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios, randomized traffic and
// counter saturation, all compared against a cycle-position reference model.
module tb_hazard_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_controller_if hif ();

    hazard_controller dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: position of the current cycle inside a multi-cycle op (0 = none) and its length.
    int mPos = 0;
    int mLen = 0;
    int mCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clearInputs();
        hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;
        hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
        hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemtoRegE = 0; hif.MemtoRegM = 0; hif.BranchD = 0; hif.PCSrcD = 0;
        hif.MultiCycleE = 0; hif.MultiLenE = 0;
    endtask

    task automatic modelMc(output bit mc, output bit busy, output int cp, output int cl);
        cl = (mPos == 0) ? int'(hif.MultiLenE) : mLen;
        cp = mPos;
        if (mPos == 0 && hif.MultiCycleE && hif.MultiLenE != 0) cp = 1;
        mc   = (cp != 0) && (cp <= cl);
        busy = (cp >= 2);
    endtask

    task automatic modelHaz(output bit lw, output bit br);
        lw = hif.MemtoRegE && hif.RtE != 0 && (hif.RtE == hif.RsD || hif.RtE == hif.RtD);
        br = hif.BranchD &&
             ((hif.RegWriteE && hif.WriteRegE != 0 &&
               (hif.WriteRegE == hif.RsD || hif.WriteRegE == hif.RtD)) ||
              (hif.MemtoRegM && hif.WriteRegM != 0 &&
               (hif.WriteRegM == hif.RsD || hif.WriteRegM == hif.RtD)));
    endtask

    function automatic int fwdRef(int src, int wrM, bit rwM, int wrW, bit rwW);
        if (src != 0 && rwM && src == wrM) return 2;
        if (src != 0 && rwW && src == wrW) return 1;
        return 0;
    endfunction

    task automatic checkOutputs();
        bit mc, busy, lw, br, st, on;
        int cp, cl;
        int eAE, eBE, eAD, eBD;
        modelMc(mc, busy, cp, cl);
        modelHaz(lw, br);
        on  = !reset;
        st  = lw | br | mc;
        eAE = on ? fwdRef(hif.RsE, hif.WriteRegM, hif.RegWriteM, hif.WriteRegW, hif.RegWriteW) : 0;
        eBE = on ? fwdRef(hif.RtE, hif.WriteRegM, hif.RegWriteM, hif.WriteRegW, hif.RegWriteW) : 0;
        eAD = (on && hif.RsD != 0 && hif.RegWriteM && hif.RsD == hif.WriteRegM) ? 1 : 0;
        eBD = (on && hif.RtD != 0 && hif.RegWriteM && hif.RtD == hif.WriteRegM) ? 1 : 0;
        checkVal("ForwardAE", 32'(hif.ForwardAE), eAE);
        checkVal("ForwardBE", 32'(hif.ForwardBE), eBE);
        checkVal("ForwardAD", 32'(hif.ForwardAD), eAD);
        checkVal("ForwardBD", 32'(hif.ForwardBD), eBD);
        checkVal("StallF", 32'(hif.StallF), 32'(on & st));
        checkVal("StallD", 32'(hif.StallD), 32'(on & st));
        checkVal("StallE", 32'(hif.StallE), 32'(on & mc));
        checkVal("BubbleM", 32'(hif.BubbleM), 32'(on & mc));
        checkVal("FlushE", 32'(hif.FlushE), 32'(on & (lw | br) & !mc));
        checkVal("FlushD", 32'(hif.FlushD), 32'(on & hif.PCSrcD & !st));
        checkVal("ExBusy", 32'(hif.ExBusy), 32'(on & busy));
        checkVal("StallCount", 32'(hif.StallCount), mCount);
    endtask

    task automatic modelAdvance();
        bit mc, busy, lw, br;
        int cp, cl;
        if (reset) begin
            mPos = 0; mLen = 0; mCount = 0;
            return;
        end
        modelMc(mc, busy, cp, cl);
        modelHaz(lw, br);
        if ((lw | br | mc) && mCount < 65535) mCount++;
        if (cp == 0 || cp == cl + 1) begin
            mPos = 0;
        end else begin
            mPos = cp + 1;
            mLen = cl;
        end
    endtask

    task automatic step();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    initial begin
        int base;
        reset = 1'b1;
        clearInputs();
        hif.RsE = 5; hif.WriteRegM = 5; hif.RegWriteM = 1; hif.MultiCycleE = 1; hif.MultiLenE = 3;
        step();
        step();
        reset = 1'b0;
        clearInputs();
        step();

        // Forwarding priority
        hif.RsE = 5; hif.WriteRegM = 5; hif.RegWriteM = 1; hif.WriteRegW = 5; hif.RegWriteW = 1;
        #1 checkVal("fwdMemPrio", 32'(hif.ForwardAE), 2);
        step();
        hif.RegWriteM = 0;
        #1 checkVal("fwdWb", 32'(hif.ForwardAE), 1);
        step();
        hif.RsE = 0;
        #1 checkVal("fwdZeroReg", 32'(hif.ForwardAE), 0);
        step();

        // Load-use
        clearInputs();
        hif.MemtoRegE = 1; hif.RtE = 8; hif.RsD = 8;
        #1 checkVal("lwStallF", 32'(hif.StallF), 1);
        checkVal("lwFlushE", 32'(hif.FlushE), 1);
        checkVal("lwStallE", 32'(hif.StallE), 0);
        step();
        hif.MemtoRegE = 0;
        #1 checkVal("lwClear", 32'(hif.StallF), 0);
        step();

        // Multi-cycle N=3
        clearInputs();
        base = mCount;
        hif.MultiCycleE = 1; hif.MultiLenE = 3;
        for (int k = 1; k <= 4; k++) begin
            #1 checkVal("mcStallE", 32'(hif.StallE), (k <= 3) ? 1 : 0);
            checkVal("mcExBusy", 32'(hif.ExBusy), (k >= 2) ? 1 : 0);
            step();
            hif.MultiCycleE = 0;
        end
        #1 checkVal("mcCount", 32'(hif.StallCount), base + 3);
        step();

        // Reset in the middle of a long op
        hif.MultiCycleE = 1; hif.MultiLenE = 15;
        for (int k = 1; k <= 4; k++) begin
            step();
            hif.MultiCycleE = 0;
        end
        reset = 1'b1;
        #1 checkVal("rstStallF", 32'(hif.StallF), 0);
        checkVal("rstExBusy", 32'(hif.ExBusy), 0);
        step();
        reset = 1'b0;
        #1 checkVal("postRstBusy", 32'(hif.ExBusy), 0);
        checkVal("postRstCount", 32'(hif.StallCount), 0);
        step();

        // Branch dependency suppresses taken-branch flush
        clearInputs();
        hif.BranchD = 1; hif.RsD = 4; hif.RegWriteE = 1; hif.WriteRegE = 4; hif.PCSrcD = 1;
        #1 checkVal("brStallD", 32'(hif.StallD), 1);
        checkVal("brFlushE", 32'(hif.FlushE), 1);
        checkVal("brFlushD", 32'(hif.FlushD), 0);
        step();
        hif.RegWriteE = 0;
        #1 checkVal("brTakenFlushD", 32'(hif.FlushD), 1);
        step();

        // Randomized traffic; small register ids so matches are frequent
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            hif.RsD = 5'($urandom_range(0, 3)); hif.RtD = 5'($urandom_range(0, 3));
            hif.RsE = 5'($urandom_range(0, 3)); hif.RtE = 5'($urandom_range(0, 3));
            hif.WriteRegE = 5'($urandom_range(0, 3));
            hif.WriteRegM = 5'($urandom_range(0, 3));
            hif.WriteRegW = 5'($urandom_range(0, 3));
            hif.RegWriteE = 1'($urandom); hif.RegWriteM = 1'($urandom);
            hif.RegWriteW = 1'($urandom); hif.MemtoRegE = ($urandom_range(0, 3) == 0);
            hif.MemtoRegM = ($urandom_range(0, 3) == 0); hif.BranchD = 1'($urandom);
            hif.PCSrcD = 1'($urandom); hif.MultiCycleE = ($urandom_range(0, 5) == 0);
            hif.MultiLenE = 4'($urandom_range(0, 5));
            step();
        end

        // Saturation
        reset = 1'b1;
        clearInputs();
        step();
        reset = 1'b0;
        hif.MemtoRegE = 1; hif.RtE = 1; hif.RsD = 1;
        repeat (65540) begin
            @(posedge clk);
            modelAdvance();
        end
        #1 checkVal("satValue", 32'(hif.StallCount), 32'hFFFF);
        step();
        step();
        #1 checkVal("satHold", 32'(hif.StallCount), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
